uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: the receive FSM encoding
// and the baud divisor derived from the system clock and line rate.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Integer clocks per bit, truncated.
    function automatic int calc_clks_per_bit(input int sys_clk, input int baud);
        return sys_clk / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RESET_VAL so an idle-high line reads as idle straight out of reset.
`timescale 1ns/1ps
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with centre-of-bit sampling, one-cycle
// rx_valid / frame_error pulses, and a break-safe wait for the line to idle.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy,
    output logic [2:0]           rx_state
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    // Terminal counts: the counter starts at 0, so N counts end at N-1.
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t              state, state_nxt;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   half_tick, bit_tick;
    logic                   cnt_clr, sample_bit, valid_set, ferr_set;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_wire),
        .q     (rx_s)
    );

    assign half_tick = (cnt == HALF_LAST);
    assign bit_tick  = (cnt == FULL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (!rx_s) state_nxt = ST_START;
                ST_START:     if (half_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:      if (bit_tick && bit_cnt == BIT_LAST) state_nxt = ST_STOP;
                ST_STOP:      if (bit_tick) state_nxt = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // Stop-bit pulses are gated by enable so an abandoned frame never reports.
    always_comb begin
        cnt_clr    = 1'b1;
        sample_bit = 1'b0;
        valid_set  = 1'b0;
        ferr_set   = 1'b0;
        if (enable) begin
            case (state)
                ST_START: cnt_clr = half_tick;
                ST_DATA: begin
                    cnt_clr    = bit_tick;
                    sample_bit = bit_tick;
                end
                ST_STOP: begin
                    cnt_clr   = bit_tick;
                    valid_set = bit_tick && rx_s;
                    ferr_set  = bit_tick && !rx_s;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            cnt         <= cnt_clr ? '0 : cnt + 1'b1;
            rx_valid    <= valid_set;
            frame_error <= ferr_set;
            if (sample_bit) begin
                shift   <= {rx_s, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state != ST_DATA) begin
                bit_cnt <= '0;
            end
            if (valid_set) rx_data <= shift;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rx_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames driven at 104167 ns/bit on a 12 MHz clock,
// expected events queued by the driver and matched by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam real CLK_HALF = 41.667;
    localparam real CLK_NS   = 2.0 * CLK_HALF;
    localparam real BIT_NS   = 104167.0;
    localparam int  W        = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       rx_wire = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, busy;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int busy_cycles = 0;

    // Each entry is {frame_error, rx_data} as seen at the pulse.
    logic [W-1:0] exp_q[$];
    realtime      ctr_q[$];
    logic [7:0]   last_good = 8'h00;

    logic [W-1:0] mon_exp;
    realtime      mon_ctr;
    logic         prev_valid = 1'b0;

    uart_rx #(.DATA_BITS(8), .BAUD(9600), .SYS_CLK(12000000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx_wire     (rx_wire),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy),
        .rx_state    (dbg_state)
    );

    always #(CLK_HALF) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_wire = b;
        #(BIT_NS);
    endtask

    // Reference model: a good stop bit delivers the byte, a bad one reports
    // a framing error with the previously delivered byte still on rx_data.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        realtime t0;
        t0 = $realtime;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (stop_ok) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        ctr_q.push_back(t0 + 9.5 * BIT_NS);
        drive_bit(stop_ok);
    endtask

    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (frame_error) ferr_cnt++;
        if (busy) busy_cycles++;
        if (rx_valid || frame_error) begin
            check("pulse_exclusive", 32'(rx_valid & frame_error), 32'd0);
            check("valid_single_cycle", 32'(rx_valid & prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: rx_valid=%0b frame_error=%0b rx_data=0x%02h, required no pulse",
                         rx_valid, frame_error, rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_ctr = ctr_q.pop_front();
                check("rx_event", 32'({frame_error, rx_data}), 32'(mon_exp));
                check("pulse_latency",
                      32'(($realtime >= mon_ctr) && ($realtime <= mon_ctr + 4.0 * CLK_NS)), 32'd1);
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        #40ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, b0;
        logic [7:0] d;
        logic       ok;

        // Reset state
        #(10.0 * CLK_NS);
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        enable = 1'b1;

        // Idle line for 1 ms
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
        #1ms;
        @(negedge clk);
        check("idle_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("idle_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("idle_busy_cycles", 32'(busy_cycles - b0), 32'd0);
        check("idle_rx_data", 32'(rx_data), 32'h00);

        // 0xA5, then 0x00 and 0x81 back-to-back
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_pulses", 32'(valid_cnt - v0), 32'd1);
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'h81, 1'b1);
        #(BIT_NS);
        @(negedge clk);
        check("b2b_pulses", 32'(valid_cnt - v0), 32'd2);
        check("b2b_rx_data", 32'(rx_data), 32'h81);

        // 30 us glitch on idle line
        v0 = valid_cnt; f0 = ferr_cnt;
        rx_wire = 1'b0;
        #10us;
        @(negedge clk);
        check("glitch_busy_rise", 32'(busy), 32'd1);
        #20us;
        rx_wire = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        check("glitch_busy_fall", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 0x3C with stop bit low, line low for two bit times
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        rx_wire = 1'b0;
        #(BIT_NS - 200.0);
        @(negedge clk);
        check("ferr_busy_while_low", 32'(busy), 32'd1);
        check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr_rx_data_held", 32'(rx_data), 32'h81);
        rx_wire = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_busy_released", 32'(busy), 32'd0);
        #(BIT_NS);

        // Reset pulse during data bit 4 of 0x5A
        d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_wire = d[4];
        #(BIT_NS / 2.0);
        @(negedge clk);
        check("rst_busy_midframe", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #5;
        check("rst_async_rx_data", 32'(rx_data), 32'h00);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_valid", 32'(rx_valid), 32'd0);
        check("rst_async_ferr", 32'(frame_error), 32'd0);
        #200;
        rst_n = 1'b1;
        last_good = 8'h00;
        rx_wire = 1'b1;
        #(5.0 * BIT_NS);
        send_frame(8'h5A, 1'b1);
        @(negedge clk);
        check("rst_next_frame", 32'(rx_data), 32'h5A);

        // Enable dropped mid-frame of 0xFF
        v0 = valid_cnt; f0 = ferr_cnt;
        d = 8'hFF;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx_wire = d[3];
        #(BIT_NS / 2.0);
        @(negedge clk);
        check("en_busy_midframe", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_busy_next_cycle", 32'(busy), 32'd0);
        #(BIT_NS / 2.0);
        for (int i = 4; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        #(BIT_NS);
        check("en_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("en_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("en_rx_data_held", 32'(rx_data), 32'h5A);
        enable = 1'b1;
        #(BIT_NS);
        send_frame(8'h7E, 1'b1);
        @(negedge clk);
        check("en_reenabled_frame", 32'(rx_data), 32'h7E);

        // Randomized frames, occasionally with a bad stop bit
        for (int n = 0; n < 3; n++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok);
            if (!ok) begin
                drive_bit(1'b0);
                drive_bit(1'b1);
            end else begin
                #(real'($urandom_range(0, 1)) * BIT_NS + real'($urandom_range(0, 300)));
            end
        end
        #(2.0 * BIT_NS);
        @(negedge clk);
        check("final_rx_data", 32'(rx_data), 32'(last_good));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
